// File: rtl/delay_line.sv
// delay_line: multi-lane complex delay line with stall, flush, valid tracking and selectable output tap
module delay_line #(
    parameter int WIDTH        = 9,
    parameter int LANES        = 16,
    parameter int DEPTH        = 4,
    parameter int ZERO_INVALID = 0,
    parameter int SELW         = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    flush,
    input  logic [SELW-1:0]         sel,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] din_re [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im [0:LANES-1],
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] dout_re [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_im [0:LANES-1],
    output logic [SELW-1:0]         occupancy
);
    logic signed [WIDTH-1:0] re_q [1:DEPTH][0:LANES-1];
    logic signed [WIDTH-1:0] re_d [1:DEPTH][0:LANES-1];
    logic signed [WIDTH-1:0] im_q [1:DEPTH][0:LANES-1];
    logic signed [WIDTH-1:0] im_d [1:DEPTH][0:LANES-1];
    logic [DEPTH:1]          v_q;
    logic [DEPTH:1]          v_d;
    logic                    cap_zero;
    logic [SELW-1:0]         tap;

    assign cap_zero  = (ZERO_INVALID != 0) && !in_valid;
    assign occupancy = SELW'($countones(v_q));

    // next stage contents: flush clears everything, en shifts din into stage 1, otherwise hold
    always_comb begin
        re_d = re_q;
        im_d = im_q;
        v_d  = v_q;
        if (flush) begin
            v_d = '0;
            for (int s = 1; s <= DEPTH; s++)
                for (int l = 0; l < LANES; l++) begin
                    re_d[s][l] = '0;
                    im_d[s][l] = '0;
                end
        end else if (en) begin
            v_d[1] = in_valid;
            for (int l = 0; l < LANES; l++) begin
                re_d[1][l] = cap_zero ? '0 : din_re[l];
                im_d[1][l] = cap_zero ? '0 : din_im[l];
            end
            for (int s = 2; s <= DEPTH; s++) begin
                v_d[s]  = v_q[s-1];
                re_d[s] = re_q[s-1];
                im_d[s] = im_q[s-1];
            end
        end
    end

    // stage registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rstn) begin
            v_q <= '0;
            for (int s = 1; s <= DEPTH; s++)
                for (int l = 0; l < LANES; l++) begin
                    re_q[s][l] <= '0;
                    im_q[s][l] <= '0;
                end
        end else begin
            v_q  <= v_d;
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    // output tap: sel=0 bypasses din, larger selects clamp to the last stage
    always_comb begin
        tap       = (sel == '0) ? SELW'(1) : (sel > SELW'(DEPTH)) ? SELW'(DEPTH) : sel;
        out_valid = (sel == '0) ? in_valid : v_q[tap];
        for (int l = 0; l < LANES; l++) begin
            dout_re[l] = (sel == '0) ? din_re[l] : re_q[tap][l];
            dout_im[l] = (sel == '0) ? din_im[l] : im_q[tap][l];
        end
    end
endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: randomized directed checks of delay_line against a history-queue model
module tb_delay_line;
    localparam int W  = 9;
    localparam int L  = 16;
    localparam int D  = 4;
    localparam int SW = $clog2(D + 1);

    typedef struct packed {
        logic         v;
        logic [L*W-1:0] re;
        logic [L*W-1:0] im;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn, en, flush, in_valid, out_valid;
    logic [SW-1:0]       sel, occupancy;
    logic signed [W-1:0] din_re [0:L-1];
    logic signed [W-1:0] din_im [0:L-1];
    logic signed [W-1:0] dout_re [0:L-1];
    logic signed [W-1:0] dout_im [0:L-1];

    slot_t hist[$];
    slot_t cur;
    int    compared = 0;
    int    mismatched = 0;

    delay_line #(.WIDTH(W), .LANES(L), .DEPTH(D), .ZERO_INVALID(1)) dut (
        .clk(clk), .rstn(rstn), .en(en), .flush(flush), .sel(sel), .in_valid(in_valid),
        .din_re(din_re), .din_im(din_im), .out_valid(out_valid),
        .dout_re(dout_re), .dout_im(dout_im), .occupancy(occupancy)
    );

    // apply one cycle's inputs with fresh random lane data, sometimes at the signed extremes
    task automatic drive(input logic r, input logic f, input logic e, input logic v, input logic [SW-1:0] s);
        rstn = r; flush = f; en = e; in_valid = v; sel = s;
        for (int l = 0; l < L; l++) begin
            din_re[l] = W'($urandom);
            din_im[l] = W'($urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
            din_re[0] = -9'sd256; din_re[1] = 9'sd255;
            din_im[0] = 9'sd255;  din_im[1] = -9'sd256;
        end
        cur.v = v;
        for (int l = 0; l < L; l++) begin
            cur.re[l*W +: W] = din_re[l];
            cur.im[l*W +: W] = din_im[l];
        end
    endtask

    // what the output should be: din for sel=0, else the k-th most recent accepted slot
    function automatic slot_t expect_slot(input logic [SW-1:0] s);
        int k;
        k = (int'(s) > D) ? D : int'(s);
        if (k == 0) return cur;
        if (hist.size() < k) return '0;
        return hist[k-1];
    endfunction

    task automatic check(input string tag);
        slot_t          e;
        logic [L*W-1:0] gr, gi;
        int             occ;
        e = expect_slot(sel);
        for (int l = 0; l < L; l++) begin
            gr[l*W +: W] = dout_re[l];
            gi[l*W +: W] = dout_im[l];
        end
        occ = 0;
        for (int i = 0; i < hist.size() && i < D; i++) occ += int'(hist[i].v);
        compared++;
        assert (gr === e.re) else begin mismatched++; $error("FAIL %s dout_re got %h exp %h", tag, gr, e.re); end
        compared++;
        assert (gi === e.im) else begin mismatched++; $error("FAIL %s dout_im got %h exp %h", tag, gi, e.im); end
        compared++;
        assert (out_valid === e.v) else begin mismatched++; $error("FAIL %s out_valid got %b exp %b", tag, out_valid, e.v); end
        compared++;
        assert (occupancy === SW'(occ)) else begin mismatched++; $error("FAIL %s occupancy got %0d exp %0d", tag, occupancy, occ); end
    endtask

    // clock edge plus model update; invalid captures are stored as zero
    task automatic tick();
        slot_t n;
        @(posedge clk);
        if (rstn || flush) hist.delete();
        else if (en) begin
            n = cur.v ? cur : slot_t'(0);
            hist.push_front(n);
            if (hist.size() > D) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        check(tag);
        tick();
    endtask

    initial begin
        logic [4:0] bub;
        bub = 5'b01101;
        // reset with live nonzero input
        drive(1, 0, 1, 1, 3'd1); tick();
        drive(1, 0, 1, 1, 3'd1); tick();
        drive(0, 0, 0, 1, 3'd0);
        for (int s = 0; s <= D; s++) begin
            sel = SW'(s); #1; check($sformatf("reset_sel%0d", s));
        end
        // latency sweep over every tap
        for (int s = 1; s <= D; s++) begin
            drive(0, 1, 1, 1, SW'(s)); cyc("lat_flush");
            for (int n = 0; n < 8; n++) begin
                drive(0, 0, 1, 1, SW'(s)); cyc($sformatf("lat_sel%0d_n%0d", s, n));
            end
        end
        // stall mid-stream
        drive(0, 1, 0, 0, 3'd3); cyc("stall_flush");
        for (int n = 0; n < 4; n++) begin drive(0, 0, 1, 1, 3'd3); cyc("stall_pre"); end
        for (int n = 0; n < 3; n++) begin drive(0, 0, 0, 1, 3'd3); cyc("stall_hold"); end
        for (int n = 0; n < 6; n++) begin drive(0, 0, 1, 1, 3'd3); cyc("stall_post"); end
        // bubbles 1,0,1,1,0 observed at the last tap
        drive(0, 1, 1, 0, 3'd4); cyc("bub_flush");
        for (int n = 0; n < 5; n++) begin drive(0, 0, 1, bub[n], 3'd4); cyc("bub_in"); end
        for (int n = 0; n < 5; n++) begin drive(0, 0, 1, 0, 3'd4); cyc("bub_out"); end
        // flush while full and streaming
        for (int n = 0; n < 4; n++) begin drive(0, 0, 1, 1, 3'd4); cyc("fl_fill"); end
        drive(0, 1, 1, 1, 3'd1); cyc("fl_flush");
        for (int n = 0; n < 5; n++) begin drive(0, 0, 1, 0, SW'(n)); cyc("fl_after"); end
        // clamp: sel=7 behaves as the last stage
        for (int n = 0; n < 6; n++) begin drive(0, 0, 1, 1, 3'd7); cyc("clamp"); end
        // reset mid-stream with flush and stall, then restart
        drive(1, 1, 0, 1, 3'd7); cyc("rst_mid");
        for (int n = 0; n < 6; n++) begin drive(0, 0, 1, 1, 3'd2); cyc("rst_restart"); end
        // random mix of everything
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), SW'($urandom_range(0, 7)));
            cyc("random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
